// File: rtl/mips_pkg.sv
// ============================================================================
//  Module : mips_pkg
//  Shared widths, NOP encoding and fetch FSM state type for the MIPS core.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

   localparam int          INST_W   = 32;
   localparam int          ADDR_W   = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
//  Module : if_id_reg
//  IF/ID pipeline register with clear (bubble), hold and load controls.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module if_id_reg #(
   parameter int                   INST_W   = 32,
   parameter int                   ADDR_W   = 32,
   parameter logic [INST_W-1:0]    NOP_INST = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_clear,
   input  logic                    i_hold,
   input  logic                    i_load,
   input  logic [INST_W-1:0]       i_inst,
   input  logic [ADDR_W-1:0]       i_pc4,
   output logic [INST_W-1:0]       o_inst,
   output logic [ADDR_W-1:0]       o_pc4,
   output logic                    o_valid
);

   logic [INST_W-1:0] r_inst;
   logic [ADDR_W-1:0] r_pc4;
   logic              r_valid;

   // Clear beats hold so a flush can squash a stalled instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inst  <= NOP_INST;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else if (i_clear) begin
         r_inst  <= NOP_INST;
         r_valid <= 1'b0;
      end else if (i_load && !i_hold) begin
         r_inst  <= i_inst;
         r_pc4   <= i_pc4;
         r_valid <= 1'b1;
      end
   end

   assign o_inst  = r_inst;
   assign o_pc4   = r_pc4;
   assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module : fetch_stage
//  Instruction fetch: PC register, next-PC selection, run/halt FSM, IF/ID reg.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
   parameter logic [mips_pkg::ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [mips_pkg::INST_W-1:0] NOP_INST = mips_pkg::NOP_INST
) (
   input  logic                          clk,
   input  logic                          rst_n,
   output logic [mips_pkg::ADDR_W-1:0]   imem_addr,
   input  logic [mips_pkg::INST_W-1:0]   imem_data,
   input  logic                          stall,
   input  logic                          flush,
   input  logic                          branch_taken,
   input  logic [mips_pkg::ADDR_W-1:0]   branch_target,
   input  logic                          halt_req,
   output logic [mips_pkg::ADDR_W-1:0]   pc,
   output logic [mips_pkg::INST_W-1:0]   if_id_inst,
   output logic [mips_pkg::ADDR_W-1:0]   if_id_pc4,
   output logic                          if_id_valid,
   output logic                          halted,
   output logic                          misalign_err
);

   import mips_pkg::*;

   localparam logic [ADDR_W-1:0] c_ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
   localparam logic [ADDR_W-1:0] c_FOUR       = ADDR_W'(4);

   fetch_state_t      r_state;
   fetch_state_t      w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [ADDR_W-1:0] w_pc4;
   logic              w_clear;
   logic              w_hold;
   logic              w_load;
   logic              w_misalign_set;
   logic              r_misalign;

   assign w_pc4 = r_pc + c_FOUR;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_misalign <= r_misalign | w_misalign_set;
      end
   end

   // Redirect outranks halt, flush and stall; halt outranks flush and stall.
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_clear        = 1'b0;
      w_hold         = 1'b1;
      w_load         = 1'b0;
      w_misalign_set = 1'b0;
      case (r_state)
         IDLE: begin
            w_state_nxt = RUN;
         end
         RUN: begin
            if (branch_taken) begin
               w_pc_nxt       = branch_target & c_ALIGN_MASK;
               w_clear        = 1'b1;
               w_misalign_set = |branch_target[1:0];
            end else if (halt_req) begin
               w_state_nxt = HALT;
               w_clear     = 1'b1;
            end else if (flush) begin
               w_clear  = 1'b1;
               w_pc_nxt = stall ? r_pc : w_pc4;
            end else if (!stall) begin
               w_hold   = 1'b0;
               w_load   = 1'b1;
               w_pc_nxt = w_pc4;
            end
         end
         HALT: begin
            w_clear = 1'b1;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   if_id_reg #(
      .INST_W   (INST_W),
      .ADDR_W   (ADDR_W),
      .NOP_INST (NOP_INST)
   ) u_if_id_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_clear),
      .i_hold  (w_hold),
      .i_load  (w_load),
      .i_inst  (imem_data),
      .i_pc4   (w_pc4),
      .o_inst  (if_id_inst),
      .o_pc4   (if_id_pc4),
      .o_valid (if_id_valid)
   );

   assign imem_addr    = r_pc;
   assign pc           = r_pc;
   assign halted       = (r_state == HALT);
   assign misalign_err = r_misalign;

endmodule

`default_nettype wire
